// File: rtl/button_press_ctrl.sv
// Debounced one-shot press sequencer for the Simon game input stage.
// Optional idle timeout pulse when BTN_TIMEOUT_EN is defined.
module button_press_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17,
    parameter int TIMEOUT_CYCLES  = 500000000,
    parameter int TO_W            = 29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pressed,
    input  logic       button_down,
    input  logic       enable,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_id,
    output logic       led_on,
    output logic [1:0] led_id,
    output logic       chord_err,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESS,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_id;
    logic [1:0]       w_id_nxt;
    logic             r_valid;
    logic             r_led;
    logic             r_chord;
    logic             w_valid_nxt;
    logic             w_led_nxt;
    logic             w_chord_nxt;
    logic             w_onehot;
    logic             w_multi;
    logic [1:0]       w_idx;
    logic [3:0]       w_latched;

    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (pressed)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    assign w_multi   = (pressed != 4'b0000) && !w_onehot;
    assign w_latched = 4'b0001 << r_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_id    <= 2'd0;
            r_valid <= 1'b0;
            r_led   <= 1'b0;
            r_chord <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_id    <= w_id_nxt;
            r_valid <= w_valid_nxt;
            r_led   <= w_led_nxt;
            r_chord <= w_chord_nxt;
        end
    end

    // cnt is zeroed on every state change; it saturates otherwise
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_id_nxt    = r_id;
        case (r_state)
            S_IDLE: begin
                if (enable && w_onehot) begin
                    w_state_nxt = S_DEBOUNCE;
                    w_cnt_nxt   = '0;
                    w_id_nxt    = w_idx;
                end
            end
            S_DEBOUNCE: begin
                if (!enable || pressed != w_latched) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_PRESS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PRESS: begin
                if (r_valid && press_ready) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE: begin
                if (button_down) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_valid_nxt = (w_state_nxt == S_PRESS);
        w_led_nxt   = (w_state_nxt == S_PRESS) ||
                      (w_state_nxt == S_RELEASE);
        w_chord_nxt = (r_state == S_IDLE) && enable && w_multi;
    end

    assign press_valid = r_valid;
    assign press_id    = r_id;
    assign led_on      = r_led;
    assign led_id      = r_id;
    assign chord_err   = r_chord;

`ifdef BTN_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_cnt_nxt;
    logic            r_timeout;
    logic            w_timeout_nxt;

    // counts only while waiting in IDLE for player input
    always_comb begin
        w_to_cnt_nxt  = '0;
        w_timeout_nxt = 1'b0;
        if (r_state == S_IDLE && enable && w_state_nxt == S_IDLE) begin
            if (r_to_cnt == TO_LAST) begin
                w_timeout_nxt = 1'b1;
            end else if (r_to_cnt == '1) begin
                w_to_cnt_nxt = r_to_cnt;
            end else begin
                w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TO_W'(TIMEOUT_CYCLES) == '0);
    assign timeout      = 1'b0;
`endif

endmodule
